// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - state/class encodings and datapath select codes for the multi-cycle controller
package mc_controller_pkg;

    typedef enum logic [3:0] {
        STATE_IDLE   = 4'd0,
        STATE_FETCH  = 4'd1,
        STATE_DECODE = 4'd2,
        STATE_EXEC   = 4'd3,
        STATE_MEMADR = 4'd4,
        STATE_MEMRD  = 4'd5,
        STATE_MEMWR  = 4'd6,
        STATE_WB_ALU = 4'd7,
        STATE_WB_MEM = 4'd8,
        STATE_BRANCH = 4'd9,
        STATE_JUMP   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLASS_ADDU, CLASS_SUBU, CLASS_SLT, CLASS_JR, CLASS_ORI, CLASS_LW, CLASS_SW,
        CLASS_BEQ, CLASS_LUI, CLASS_J, CLASS_ADDI, CLASS_ADDIU, CLASS_JAL, CLASS_ILLEGAL
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2A;

    localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_RET = 2'd2;
    localparam logic [1:0] MEM2REG_ALU = 2'd0, MEM2REG_RAM = 2'd1, MEM2REG_RET = 2'd2;
    localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'd0, NPC_SEL_BEQ_JMP = 2'd1;
    localparam logic [1:0] NPC_SEL_J_JMP = 2'd2, NPC_SEL_REG_JMP = 2'd3;
    localparam logic [1:0] EXT_OP_ZERO = 2'd0, EXT_OP_SIGN = 2'd1, EXT_OP_HIGH = 2'd2;
    localparam logic       ALU_SRC_B = 1'b0, ALU_SRC_EXT = 1'b1;
    localparam logic [2:0] ALU_OP_ADD = 3'd0, ALU_OP_SUB = 3'd1, ALU_OP_OR = 3'd2, ALU_OP_SLT = 3'd3;

    typedef struct packed {
        logic [1:0] regdst;
        logic       alusrc;
        logic [1:0] extop;
        logic [2:0] aluop;
    } alu_ctrl_t;

    // Datapath selects shared by EXEC and WB_ALU for the ALU-class instructions.
    function automatic alu_ctrl_t alu_ctrl(input class_t c);
        alu_ctrl_t a;
        a = '{regdst: REGDST_RT, alusrc: ALU_SRC_B, extop: EXT_OP_ZERO, aluop: ALU_OP_ADD};
        case (c)
            CLASS_ADDU:  a.regdst = REGDST_RD;
            CLASS_SUBU:  begin a.regdst = REGDST_RD; a.aluop = ALU_OP_SUB; end
            CLASS_SLT:   begin a.regdst = REGDST_RD; a.aluop = ALU_OP_SLT; end
            CLASS_ORI:   begin a.alusrc = ALU_SRC_EXT; a.aluop = ALU_OP_OR; end
            CLASS_LUI:   begin a.alusrc = ALU_SRC_EXT; a.extop = EXT_OP_HIGH; end
            CLASS_ADDI, CLASS_ADDIU: begin a.alusrc = ALU_SRC_EXT; a.extop = EXT_OP_SIGN; end
            default:     a = a;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mc_controller_decoder.sv
// rtl/mc_controller_decoder.sv - combinational opcode/funct to instruction class decode
module instr_decoder
    import mc_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output class_t     cls
);

    always_comb begin
        cls = CLASS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CLASS_ADDU;
                    FN_SUBU: cls = CLASS_SUBU;
                    FN_SLT:  cls = CLASS_SLT;
                    FN_JR:   cls = CLASS_JR;
                    default: cls = CLASS_ILLEGAL;
                endcase
            end
            OP_ORI:   cls = CLASS_ORI;
            OP_LW:    cls = CLASS_LW;
            OP_SW:    cls = CLASS_SW;
            OP_BEQ:   cls = CLASS_BEQ;
            OP_LUI:   cls = CLASS_LUI;
            OP_J:     cls = CLASS_J;
            OP_ADDI:  cls = CLASS_ADDI;
            OP_ADDIU: cls = CLASS_ADDIU;
            OP_JAL:   cls = CLASS_JAL;
            default:  cls = CLASS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control unit: state register, class register, output decode
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       ALUSrc,
    output logic       SetFlag,
    output logic [1:0] RegDst,
    output logic [1:0] Mem2Reg,
    output logic [1:0] NPCSel,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    state_t    cur_state, nxt_state;
    class_t    dec_cls, cls_q;
    alu_ctrl_t ac;

    instr_decoder u_dec (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= STATE_IDLE;
            cls_q     <= CLASS_ILLEGAL;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == STATE_DECODE)
                cls_q <= dec_cls;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0;
        ALUSrc = ALU_SRC_B; SetFlag = 1'b0; illegal = 1'b0;
        RegDst = REGDST_RT; Mem2Reg = MEM2REG_ALU; NPCSel = NPC_SEL_PC_ADD_4;
        EXTOp = EXT_OP_ZERO; ALUOp = ALU_OP_ADD;
        ac = alu_ctrl(cls_q);
        case (cur_state)
            STATE_IDLE:  nxt_state = STATE_FETCH;
            STATE_FETCH: begin
                IRWr      = 1'b1;
                nxt_state = STATE_DECODE;
            end
            // Routing uses the live decode; the class register loads on this same edge.
            STATE_DECODE: begin
                case (dec_cls)
                    CLASS_LW, CLASS_SW:  nxt_state = STATE_MEMADR;
                    CLASS_BEQ:           nxt_state = STATE_BRANCH;
                    CLASS_J, CLASS_JAL, CLASS_JR: nxt_state = STATE_JUMP;
                    CLASS_ILLEGAL: begin
                        PCWr      = 1'b1;
                        illegal   = 1'b1;
                        nxt_state = STATE_FETCH;
                    end
                    default:             nxt_state = STATE_EXEC;
                endcase
            end
            STATE_EXEC, STATE_WB_ALU: begin
                RegDst = ac.regdst; ALUSrc = ac.alusrc; EXTOp = ac.extop; ALUOp = ac.aluop;
                if (cur_state == STATE_EXEC) begin
                    nxt_state = STATE_WB_ALU;
                end else begin
                    RegWr     = 1'b1;
                    PCWr      = 1'b1;
                    SetFlag   = (cls_q == CLASS_ADDI);
                    nxt_state = STATE_FETCH;
                end
            end
            STATE_MEMADR, STATE_MEMRD, STATE_MEMWR: begin
                ALUSrc = ALU_SRC_EXT; EXTOp = EXT_OP_SIGN; ALUOp = ALU_OP_ADD;
                if (cur_state == STATE_MEMADR) begin
                    nxt_state = (cls_q == CLASS_LW) ? STATE_MEMRD : STATE_MEMWR;
                end else if (cur_state == STATE_MEMRD) begin
                    if (mem_ready) nxt_state = STATE_WB_MEM;
                end else begin
                    MemWr = 1'b1;
                    if (mem_ready) begin
                        PCWr      = 1'b1;
                        nxt_state = STATE_FETCH;
                    end
                end
            end
            STATE_WB_MEM: begin
                RegDst = REGDST_RT; Mem2Reg = MEM2REG_RAM;
                RegWr = 1'b1; PCWr = 1'b1;
                nxt_state = STATE_FETCH;
            end
            STATE_BRANCH: begin
                ALUSrc = ALU_SRC_B; ALUOp = ALU_OP_SUB; PCWr = 1'b1;
                NPCSel = zero ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
                nxt_state = STATE_FETCH;
            end
            STATE_JUMP: begin
                PCWr   = 1'b1;
                NPCSel = (cls_q == CLASS_JR) ? NPC_SEL_REG_JMP : NPC_SEL_J_JMP;
                if (cls_q == CLASS_JAL) begin
                    RegDst = REGDST_RET; Mem2Reg = MEM2REG_RET; RegWr = 1'b1;
                end
                nxt_state = STATE_FETCH;
            end
            default: nxt_state = STATE_IDLE;
        endcase
    end

    assign retire = PCWr && (cur_state != STATE_DECODE);
    assign state  = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller with directed instruction vectors
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, SetFlag, retire, illegal;
    logic [1:0] RegDst, Mem2Reg, NPCSel, EXTOp;
    logic [2:0] ALUOp;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        logic [31:0] trace;
        int npc, regdst, m2r, regwr, memwr, ill, sf, aluop, extop, alusrc;
    } exp_t;

    exp_t sb[$];

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .ALUSrc(ALUSrc), .SetFlag(SetFlag), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
        .NPCSel(NPCSel), .EXTOp(EXTOp), .ALUOp(ALUOp), .retire(retire),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [31:0] trace, input int npc,
                                input int regdst, input int m2r, input int regwr, input int memwr,
                                input int ill, input int sf, input int aluop, input int extop,
                                input int alusrc);
        exp_t e;
        e.lat = lat; e.trace = trace; e.npc = npc; e.regdst = regdst; e.m2r = m2r;
        e.regwr = regwr; e.memwr = memwr; e.ill = ill; e.sf = sf; e.aluop = aluop;
        e.extop = extop; e.alusrc = alusrc;
        return e;
    endfunction

    // Monitor: accumulates per-instruction activity and checks it when the instruction ends.
    int          m_lat, m_pcwr, m_regwr, m_memwr, m_irwr, overlap, retires;
    logic [31:0] m_trace;
    initial begin
        m_lat = 0; m_pcwr = 0; m_regwr = 0; m_memwr = 0; m_irwr = 0;
        overlap = 0; retires = 0; m_trace = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_lat = 0; m_trace = '0;
                m_pcwr = 0; m_regwr = 0; m_memwr = 0; m_irwr = 0;
            end else if (state != 4'd0) begin
                if (state == 4'd1) begin
                    m_lat = 1; m_trace = 32'h1;
                    m_pcwr = 0; m_regwr = 0; m_memwr = 0; m_irwr = 0;
                end else begin
                    m_lat++;
                    m_trace = {m_trace[27:0], state};
                end
                m_pcwr  += int'(PCWr);
                m_regwr += int'(RegWr);
                m_memwr += int'(MemWr);
                m_irwr  += int'(IRWr);
                if (MemWr && RegWr) overlap++;
                if (retire) retires++;
                if (retire || illegal) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("latency", m_lat, e.lat);
                        chk("state_trace", int'(m_trace), int'(e.trace));
                        chk("npcsel", int'(NPCSel), e.npc);
                        chk("regdst", int'(RegDst), e.regdst);
                        chk("mem2reg", int'(Mem2Reg), e.m2r);
                        chk("regwr_cycles", m_regwr, e.regwr);
                        chk("memwr_cycles", m_memwr, e.memwr);
                        chk("pcwr_cycles", m_pcwr, 1);
                        chk("irwr_cycles", m_irwr, 1);
                        chk("illegal", int'(illegal), e.ill);
                        chk("retire", int'(retire), 1 - e.ill);
                        chk("setflag", int'(SetFlag), e.sf);
                        chk("aluop", int'(ALUOp), e.aluop);
                        chk("extop", int'(EXTOp), e.extop);
                        chk("alusrc", int'(ALUSrc), e.alusrc);
                    end
                end
            end
        end
    end

    // Drives one instruction; the bench's memory answers after w not-ready cycles.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int w, input exp_t e);
        int  wcnt;
        bit  done;
        wcnt = 0; done = 0;
        sb.push_back(e);
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (state == 4'd5 || state == 4'd6) begin
                mem_ready = (wcnt == w);
                wcnt++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (retire || illegal) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            chk("instr_timeout", 0, 1);
            void'(sb.pop_back());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int legal;
        bit hit;
        legal = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'({PCWr, IRWr, RegWr, MemWr, ALUSrc, SetFlag, RegDst,
                                    Mem2Reg, NPCSel, EXTOp, ALUOp, retire, illegal}), 0);
        rst = 1'b0;
        #1;
        chk("idle_after_release", int'(state), 0);
        @(posedge clk); #1;
        chk("first_fetch_state", int'(state), 1);
        chk("first_fetch_irwr", int'(IRWr), 1);

        run(6'h00, 6'h21, 1'b0, 0, mk(4, 32'h1237, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h00, 6'h23, 1'b0, 0, mk(4, 32'h1237, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0)); legal++;
        run(6'h00, 6'h2A, 1'b0, 0, mk(4, 32'h1237, 0, 1, 0, 1, 0, 0, 0, 3, 0, 0)); legal++;
        run(6'h08, 6'h21, 1'b0, 0, mk(4, 32'h1237, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1)); legal++;
        run(6'h09, 6'h00, 1'b0, 0, mk(4, 32'h1237, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1)); legal++;
        run(6'h0D, 6'h00, 1'b0, 0, mk(4, 32'h1237, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1)); legal++;
        run(6'h0F, 6'h00, 1'b0, 0, mk(4, 32'h1237, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1)); legal++;
        run(6'h23, 6'h00, 1'b0, 2, mk(7, 32'h1245558, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h23, 6'h00, 1'b0, 0, mk(5, 32'h12458, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h2B, 6'h00, 1'b0, 0, mk(4, 32'h1246, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1)); legal++;
        run(6'h2B, 6'h00, 1'b0, 1, mk(5, 32'h12466, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1)); legal++;
        run(6'h04, 6'h00, 1'b1, 0, mk(3, 32'h129, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); legal++;
        run(6'h04, 6'h00, 1'b0, 0, mk(3, 32'h129, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); legal++;
        run(6'h02, 6'h00, 1'b0, 0, mk(3, 32'h12A, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h03, 6'h00, 1'b0, 0, mk(3, 32'h12A, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h00, 6'h08, 1'b0, 0, mk(3, 32'h12A, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0)); legal++;
        run(6'h3F, 6'h00, 1'b0, 0, mk(2, 32'h12, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run(6'h00, 6'h00, 1'b0, 0, mk(2, 32'h12, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // sw stalled in MEMWR, then reset mid-cycle: MemWr must drop without a retire.
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (state == 4'd6) begin hit = 1; break; end
        end
        chk("reached_memwr", int'(hit), 1);
        #2;
        chk("memwr_before_reset", int'(MemWr), 1);
        rst = 1'b1;
        #1;
        chk("memwr_async_reset", int'(MemWr), 0);
        chk("state_async_reset", int'(state), 0);
        chk("pcwr_async_reset", int'(PCWr), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        run(6'h00, 6'h21, 1'b0, 0, mk(4, 32'h1237, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); legal++;

        chk("scoreboard_drained", sb.size(), 0);
        chk("retire_count", retires, legal);
        chk("memwr_regwr_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the PCOCD MIPS datapath. It sequences one instruction over 3–5+ cycles (fetch, decode, execute, memory, write-back) and drives the same datapath control signals as the single-cycle controller. It adds PC/IR write enables and a data-memory ready handshake. It sits between the IR/ALU-zero outputs and the register file, ALU, EXT, NPC and data-memory control inputs.

## Interface
- No parameters; all encodings come from macro.v.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- zero  in  1  ALU zero flag, combinational in the current cycle
- mem_ready  in  1  data memory completed the current read/write this cycle
- PCWr, IRWr, RegWr, MemWr  out  1  write enables
- ALUSrc, SetFlag  out  1  datapath selects, macro.v codes
- RegDst, Mem2Reg, NPCSel, EXTOp  out  2  macro.v codes
- ALUOp  out  3  macro.v code
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse when an unsupported instruction is skipped
- state  out  4  current state, for debug

## Operation
- Supported instructions: addu, subu, slt, jr, ori, lw, sw, beq, lui, j, addi, addiu, jal. Every other opcode/funct combination is illegal.
- States and transitions:
  - IDLE → FETCH
  - FETCH → DECODE
  - DECODE → one of: EXEC (R-type, ori, lui, addi, addiu); MEMADR (lw, sw); BRANCH (beq); JUMP (j, jal, jr); FETCH (illegal)
  - EXEC → WB_ALU
  - MEMADR → MEMRD (lw) or MEMWR (sw)
  - MEMRD → WB_MEM when mem_ready=1, else stay in MEMRD
  - MEMWR → FETCH when mem_ready=1, else stay in MEMWR
  - WB_ALU, WB_MEM, BRANCH, JUMP → FETCH
- Instruction class is decoded from opcode/funct in DECODE and latched into a class register. All later states use the latched class, not live IR bits.
- Per-state outputs (all unlisted enables 0, unlisted selects 0):
  - FETCH: IRWr=1.
  - EXEC/WB_ALU: RegDst, ALUSrc, EXTOp, ALUOp, Mem2Reg=ALU as the single-cycle table, except addi/addiu use EXT_OP_SIGN. SetFlag=1 for addi, in WB_ALU only.
  - WB_ALU: RegWr=1, PCWr=1, NPCSel=PC_ADD_4.
  - MEMADR/MEMRD/MEMWR: ALUSrc=EXT, EXTOp=SIGN, ALUOp=ADD held throughout.
  - MEMWR: MemWr=1 while in the state; PCWr=1 only in the cycle mem_ready=1.
  - WB_MEM: RegDst=RT, Mem2Reg=RAM, RegWr=1, PCWr=1.
  - BRANCH: ALUSrc=B, ALUOp=SUB, PCWr=1; NPCSel=BEQ_JMP if zero else PC_ADD_4.
  - JUMP: PCWr=1; NPCSel=J_JMP for j/jal, REG_JMP for jr. jal also drives RegDst=RET, Mem2Reg=RET, RegWr=1.
  - DECODE (illegal class): PCWr=1, NPCSel=PC_ADD_4, illegal=1.
- retire=1 in every cycle where PCWr=1 and the instruction is legal.

## Timing
- Reset: state=IDLE asynchronously; all outputs 0, including state=0.
- First FETCH occurs in the first cycle after rst deasserts.
- Latency, FETCH to last cycle inclusive:
  - beq, j, jal, jr: 3 cycles
  - ALU instructions: 4 cycles
  - sw: 4+w cycles; lw: 5+w cycles; w = number of MEMRD/MEMWR cycles with mem_ready=0
  - illegal: 2 cycles
- PCWr is asserted exactly once per instruction, in its final cycle. PC therefore changes on the edge that enters FETCH.
- mem_ready is ignored outside MEMRD/MEMWR.
- MemWr is never asserted in the same cycle as RegWr.
- Reset during MEMWR: MemWr falls immediately (asynchronous); no retire pulse is produced.
- zero is used only in BRANCH.

## Structure
- macro.v gains STATE_* (4-bit) and CLASS_* codes; existing REGDST_/ALU_OP_/NPC_SEL_ macros are reused unchanged.
- Sub-module instr_decoder: combinational opcode/funct → CLASS_* code. Reusable by the single-cycle controller.
- mc_controller contains the state register, class register and the output decode.

## Test plan
- rst pulse mid-cycle → outputs 0 immediately; IDLE, then FETCH with IRWr=1 one cycle after release.
- addu (opcode 0x00, funct 0x21) → states FETCH, DECODE, EXEC, WB_ALU; RegWr=1, RegDst=RD, PCWr=1 only in cycle 4; retire pulse.
- lw (0x23) with mem_ready low for 2 cycles → MEMRD held 3 cycles, WB_MEM with Mem2Reg=RAM; 7 cycles total.
- sw (0x2B), mem_ready=1 immediately → MemWr high for 1 cycle, RegWr stays 0; 4 cycles total.
- beq (0x04) with zero=1, then zero=0 → NPCSel=BEQ_JMP, then PC_ADD_4; each instruction takes 3 cycles.
- jal (0x03) → JUMP with RegDst=RET, RegWr=1; opcode 0x3F → illegal pulse in DECODE, back to FETCH.
